// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: one write port plus NUM_READ packed read ports.
// There is no handshake: the write strobe is sampled on every rising edge and reads never stall.
interface regfile_multiport_if #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                       ctrl_writeEnable;
  logic [ADDR_W-1:0]          ctrl_writeReg;
  logic [WIDTH-1:0]           data_writeReg;
  logic [NUM_READ*ADDR_W-1:0] ctrl_readReg;
  logic [NUM_READ*WIDTH-1:0]  data_readReg;
  logic [NUM_READ-1:0]        read_written;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
    input  data_readReg, read_written
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_readReg,
    output data_readReg, read_written
  );
endinterface

// File: rtl/regfile_multiport.sv
// Register file with one write port and NUM_READ independent read ports built from one-hot
// AND-OR muxes, with optional write bypass, optional output register and a hardwired zero entry.
module regfile_multiport #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int NUM_READ     = 2,
  parameter int READ_LATENCY = 0,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 1
) (
  input logic                clock,
  input logic                ctrl_reset,
  regfile_multiport_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic             write_ok;

  // A write to the zero entry is discarded everywhere, including the bypass path.
  assign write_ok = bus.ctrl_writeEnable && !((ZERO_REG != 0) && (bus.ctrl_writeReg == '0));

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else if (write_ok) begin
      mem[bus.ctrl_writeReg]     <= bus.data_writeReg;
      written[bus.ctrl_writeReg] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DEPTH-1:0]  sel;
    logic [WIDTH-1:0]  mux_data;
    logic [WIDTH-1:0]  comb_data;
    logic              mux_flag;
    logic              comb_flag;
    logic              is_zero;
    logic              hit;

    assign addr    = bus.ctrl_readReg[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && write_ok && (bus.ctrl_writeReg == addr);

    always_comb begin
      sel       = '0;
      sel[addr] = 1'b1;
      mux_data  = '0;
      mux_flag  = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        mux_data = mux_data | (mem[e] & {WIDTH{sel[e]}});
        mux_flag = mux_flag | (written[e] & sel[e]);
      end
    end

    always_comb begin
      comb_data = mux_data;
      comb_flag = mux_flag;
      if (is_zero) begin
        comb_data = '0;
        comb_flag = 1'b1;
      end else if (hit) begin
        comb_data = bus.data_writeReg;
        comb_flag = 1'b1;
      end
    end

    if (READ_LATENCY == 0) begin : g_comb
      assign bus.data_readReg[p*WIDTH +: WIDTH] = comb_data;
      assign bus.read_written[p]                = comb_flag;
    end else begin : g_reg
      // With BYPASS=0 comb_data holds the pre-write value at the edge, giving old data here.
      logic [WIDTH-1:0] q_data;
      logic             q_flag;
      always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
          q_data <= '0;
          q_flag <= 1'b0;
        end else begin
          q_data <= comb_data;
          q_flag <= comb_flag;
        end
      end
      assign bus.data_readReg[p*WIDTH +: WIDTH] = q_data;
      assign bus.read_written[p]                = q_flag;
    end
  end
endmodule
